// File: rtl/nsl_step_controller.sv
// Step sequencer for an external combinational next-state block: holds the state vector,
// waits SETTLE cycles, then streams each response over valid/ready while accumulating toggles.
// Optional build macro NSL_FIXPOINT_STOP_EN ends a run early when the block reaches a fixed point.
module nsl_step_controller #(
    parameter int W      = 9,
    parameter int CNT_W  = 16,
    parameter int TOG_W  = 20,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_steps_i,
    input  logic [W-1:0]     seed_i,
    output logic [W-1:0]     state_o,
    input  logic [W-1:0]     next_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [W-1:0]     trace_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic [TOG_W-1:0] toggle_acc_o,
    output logic             fixpoint_o
);

    localparam int POP_W = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } fsm_t;

    fsm_t             fsm_reg;
    logic [W-1:0]     state_reg;
    logic [W-1:0]     seed_reg;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] step_cnt_reg;
    logic [TOG_W-1:0] toggle_acc_reg;
    logic [3:0]       settle_cnt_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [W-1:0]     diff;
    logic [POP_W-1:0] pop_count;
    logic [TOG_W:0]   toggle_sum;
    logic [TOG_W-1:0] toggle_next;
    logic [CNT_W-1:0] step_next;
    logic             end_run;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_diff
            assign diff[gi] = state_reg[gi] ^ next_i[gi];
        end
    endgenerate

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < W; i++) begin
            pop_count = pop_count + POP_W'(diff[i]);
        end
    end

    // One extra bit on the sum exposes the carry used for saturation.
    assign toggle_sum  = {1'b0, toggle_acc_reg} + (TOG_W + 1)'(pop_count);
    assign toggle_next = toggle_sum[TOG_W] ? '1 : toggle_sum[TOG_W-1:0];
    assign step_next   = step_cnt_reg + CNT_W'(1);

`ifdef NSL_FIXPOINT_STOP_EN
    logic fixpoint_reg;
    logic fix_hit;
    assign fix_hit    = (next_i == state_reg);
    assign end_run    = (step_next == num_reg) || fix_hit;
    assign fixpoint_o = fixpoint_reg;
`else
    assign end_run    = (step_next == num_reg);
    assign fixpoint_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg        <= S_IDLE;
            state_reg      <= '0;
            seed_reg       <= '0;
            num_reg        <= '0;
            step_cnt_reg   <= '0;
            toggle_acc_reg <= '0;
            settle_cnt_reg <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef NSL_FIXPOINT_STOP_EN
            fixpoint_reg   <= 1'b0;
`endif
        end else if (abort_i && fsm_reg != S_IDLE) begin
            // Abort beats any accept in the same cycle; counters and state are left as they are.
            fsm_reg   <= S_IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                S_IDLE: begin
                    if (start_i) begin
                        seed_reg <= seed_i;
                        num_reg  <= num_steps_i;
                        busy_reg <= 1'b1;
                        fsm_reg  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_reg      <= seed_reg;
                    step_cnt_reg   <= '0;
                    toggle_acc_reg <= '0;
                    settle_cnt_reg <= '0;
`ifdef NSL_FIXPOINT_STOP_EN
                    fixpoint_reg   <= 1'b0;
`endif
                    if (num_reg == '0) begin
                        done_reg <= 1'b1;
                        fsm_reg  <= S_DONE;
                    end else begin
                        fsm_reg  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == 4'(SETTLE - 1)) begin
                        valid_reg <= 1'b1;
                        fsm_reg   <= S_CAPTURE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (trace_ready_i) begin
                        state_reg      <= next_i;
                        step_cnt_reg   <= step_next;
                        toggle_acc_reg <= toggle_next;
                        valid_reg      <= 1'b0;
                        settle_cnt_reg <= '0;
`ifdef NSL_FIXPOINT_STOP_EN
                        if (fix_hit) begin
                            fixpoint_reg <= 1'b1;
                        end
`endif
                        if (end_run) begin
                            done_reg <= 1'b1;
                            fsm_reg  <= S_DONE;
                        end else begin
                            fsm_reg  <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    busy_reg <= 1'b0;
                    fsm_reg  <= S_IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    fsm_reg   <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o       = state_reg;
    assign trace_valid_o = valid_reg;
    assign trace_data_o  = valid_reg ? next_i : '0;
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign step_cnt_o    = step_cnt_reg;
    assign toggle_acc_o  = toggle_acc_reg;

endmodule

// File: tb/tb_nsl_step_controller.sv
// Directed bench for nsl_step_controller: rotate-left (or all-zero) combinational block model,
// hand-computed expectations for timing, trace data, toggles, abort, reset and fixpoint stop.
module tb_nsl_step_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [15:0] num_steps_i;
    logic [8:0]  seed_i;
    logic [8:0]  state_o;
    logic [8:0]  next_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [8:0]  trace_data_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] step_cnt_o;
    logic [19:0] toggle_acc_o;
    logic        fixpoint_o;

    bit          zero_mode = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [8:0]  cap_q[$];

    always #5 clk = ~clk;

    // External combinational block: rotate left by one, or constant zero.
    assign next_i = zero_mode ? 9'h000 : {state_o[7:0], state_o[8]};

    nsl_step_controller dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .num_steps_i   (num_steps_i),
        .seed_i        (seed_i),
        .state_o       (state_o),
        .next_i        (next_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .step_cnt_o    (step_cnt_o),
        .toggle_acc_o  (toggle_acc_o),
        .fixpoint_o    (fixpoint_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(trace_valid_o), 32'd0);
        chk({tag, "_data"}, 32'(trace_data_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_step"}, 32'(step_cnt_o), 32'd0);
        chk({tag, "_tog"}, 32'(toggle_acc_o), 32'd0);
        chk({tag, "_fix"}, 32'(fixpoint_o), 32'd0);
    endtask

    // Runs one job; cycle 0 is the cycle start_i is sampled. done_cyc = -1 if no done_o was seen.
    task automatic run(input logic [8:0] seed, input logic [15:0] n, input int stall,
                       input int abort_at, input bit start_hold,
                       output int done_cyc, output int nacc, output int nvalid);
        int         cyc;
        int         stall_left;
        logic [8:0] model;
        cyc        = 0;
        done_cyc   = -1;
        nacc       = 0;
        nvalid     = 0;
        stall_left = stall;
        model      = seed;
        cap_q.delete();
        seed_i        = seed;
        num_steps_i   = n;
        start_i       = 1'b1;
        trace_ready_i = 1'b1;
        tick();
        cyc = 1;
        // Scrambled start inputs must not disturb a busy run.
        start_i     = start_hold;
        seed_i      = 9'h1FF;
        num_steps_i = 16'd0;
        while (cyc < 100 && done_cyc < 0) begin
            abort_i       = (cyc == abort_at);
            trace_ready_i = 1'b1;
            if (trace_valid_o) begin
                nvalid++;
                if (stall_left > 0) begin
                    trace_ready_i = 1'b0;
                    stall_left--;
                    chk("stall_data", 32'(trace_data_o), 32'(zero_mode ? 9'h000 : {model[7:0], model[8]}));
                end else if (!abort_i) begin
                    model = zero_mode ? 9'h000 : {model[7:0], model[8]};
                    chk("trace_data", 32'(trace_data_o), 32'(model));
                    cap_q.push_back(trace_data_o);
                    $display("cycle %0d step %0d data=0x%03h", cyc, nacc, trace_data_o);
                    nacc++;
                end
            end
            if (done_o) begin
                done_cyc = cyc;
            end else begin
                tick();
                cyc++;
                if (abort_at != 0 && cyc == abort_at + 1) break;
            end
        end
        start_i       = 1'b0;
        abort_i       = 1'b0;
        trace_ready_i = 1'b1;
        $display("run seed=0x%03h n=%0d stall=%0d abort_at=%0d -> done_cyc=%0d accepted=%0d",
                 seed, n, stall, abort_at, done_cyc, nacc);
    endtask

    initial begin
        int dc, na, nv;
        rst           = 1'b1;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        num_steps_i   = 16'd0;
        seed_i        = 9'h000;
        trace_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle_zero("reset");
        tick();
        chk_idle_zero("idle");

        // Basic 3-step rotate run
        run(9'h014, 16'd3, 0, 0, 1'b0, dc, na, nv);
        chk("r1_done_cyc", 32'(dc), 32'd8);
        chk("r1_busy_at_done", 32'(busy_o), 32'd1);
        chk("r1_step", 32'(step_cnt_o), 32'd3);
        chk("r1_tog", 32'(toggle_acc_o), 32'd12);
        chk("r1_state", 32'(state_o), 32'h0A0);
        chk("r1_nacc", 32'(na), 32'd3);
        if (cap_q.size() == 3) begin
            chk("r1_d0", 32'(cap_q[0]), 32'h028);
            chk("r1_d1", 32'(cap_q[1]), 32'h050);
            chk("r1_d2", 32'(cap_q[2]), 32'h0A0);
        end else begin
            chk("r1_capq_size", 32'(cap_q.size()), 32'd3);
        end
        tick();
        chk("r1_done_pulse", 32'(done_o), 32'd0);
        chk("r1_idle_busy", 32'(busy_o), 32'd0);
        chk("r1_step_hold", 32'(step_cnt_o), 32'd3);

        // Same run, 4-cycle stall at first capture, start_i held high throughout
        run(9'h014, 16'd3, 4, 0, 1'b1, dc, na, nv);
        chk("r2_done_cyc", 32'(dc), 32'd12);
        chk("r2_tog", 32'(toggle_acc_o), 32'd12);
        chk("r2_step", 32'(step_cnt_o), 32'd3);
        chk("r2_nvalid", 32'(nv), 32'd7);
        tick();

        // Zero-step run
        run(9'h1FF, 16'd0, 0, 0, 1'b0, dc, na, nv);
        chk("r3_done_cyc", 32'(dc), 32'd2);
        chk("r3_state", 32'(state_o), 32'h1FF);
        chk("r3_nvalid", 32'(nv), 32'd0);
        chk("r3_step", 32'(step_cnt_o), 32'd0);
        chk("r3_tog", 32'(toggle_acc_o), 32'd0);
        tick();

        // Abort in second SETTLE (cycle 4) of a 5-step run
        run(9'h014, 16'd5, 0, 4, 1'b0, dc, na, nv);
        chk("ab_no_done_seen", 32'(dc), 32'hFFFF_FFFF);
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_valid", 32'(trace_valid_o), 32'd0);
        chk("ab_done", 32'(done_o), 32'd0);
        chk("ab_step", 32'(step_cnt_o), 32'd1);
        chk("ab_tog", 32'(toggle_acc_o), 32'd4);
        chk("ab_state", 32'(state_o), 32'h028);
        tick();
        chk("ab_done_next", 32'(done_o), 32'd0);
        run(9'h014, 16'd3, 0, 0, 1'b0, dc, na, nv);
        chk("ab_rerun_done_cyc", 32'(dc), 32'd8);
        chk("ab_rerun_step", 32'(step_cnt_o), 32'd3);
        chk("ab_rerun_tog", 32'(toggle_acc_o), 32'd12);
        tick();

        // Fixed-point block
        zero_mode = 1'b1;
        run(9'h000, 16'd10, 0, 0, 1'b0, dc, na, nv);
`ifdef NSL_FIXPOINT_STOP_EN
        chk("fp_done_cyc", 32'(dc), 32'd4);
        chk("fp_step", 32'(step_cnt_o), 32'd1);
        chk("fp_fix", 32'(fixpoint_o), 32'd1);
        chk("fp_tog", 32'(toggle_acc_o), 32'd0);
        tick();
        chk("fp_fix_hold", 32'(fixpoint_o), 32'd1);
`else
        chk("fp_done_cyc", 32'(dc), 32'd22);
        chk("fp_step", 32'(step_cnt_o), 32'd10);
        chk("fp_fix", 32'(fixpoint_o), 32'd0);
        chk("fp_tog", 32'(toggle_acc_o), 32'd0);
        tick();
`endif
        zero_mode = 1'b0;

        // Reset held two cycles while stalled in CAPTURE
        seed_i        = 9'h014;
        num_steps_i   = 16'd3;
        start_i       = 1'b1;
        trace_ready_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("rst_pre_valid", 32'(trace_valid_o), 32'd1);
        chk("rst_pre_data", 32'(trace_data_o), 32'h028);
        rst = 1'b1;
        tick();
        chk_idle_zero("rst1");
        tick();
        rst = 1'b0;
        chk_idle_zero("rst2");
        tick();
        chk_idle_zero("rst_after");
        trace_ready_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nsl_step_controller.md
Name: nsl_step_controller

Overview:
- Sequencer that drives an external, purely combinational FSM next-state/output block, such as the flattened benchmark FSM netlists in the power-aware synthesis train set.
- Holds the W-bit state vector in a register and presents it to the block.
- Waits a programmable settle time, then captures the block's response and streams each step to a trace consumer via valid/ready.
- Accumulates the bit-toggle count of the state vector, which feeds switching-activity (power) estimation for the RL flow.

Parameters:
- W, 9, width of the state/response vector exchanged with the combinational block
- CNT_W, 16, width of the step-count request and step counter
- TOG_W, 20, width of the saturating toggle accumulator
- SETTLE, 1, cycles waited after each state update before capture; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  start a run; honoured only in IDLE
- abort_i  in  1  cancel the current run
- num_steps_i  in  CNT_W  steps to run; sampled with start_i
- seed_i  in  W  initial state vector; sampled with start_i
- state_o  out  W  current state vector driven to the combinational block
- next_i  in  W  combinational block response to state_o
- trace_valid_o  out  1  captured step available
- trace_ready_i  in  1  consumer accepts the step
- trace_data_o  out  W  response being offered (next_i captured view)
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at normal completion
- step_cnt_o  out  CNT_W  steps completed in the current or last run
- toggle_acc_o  out  TOG_W  sum of popcount(state_o ^ next_i) over accepted steps
- fixpoint_o  out  1  run ended on a fixed point (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state register 0; FSM in IDLE.
- States:
  - IDLE: on start_i, latch num_steps_i and seed_i and go to LOAD.
  - LOAD (1 cycle): state reg <= seed; step_cnt and toggle_acc <= 0; fixpoint_o <= 0. Next state is DONE if num_steps == 0, else SETTLE.
  - SETTLE: counts SETTLE cycles, then goes to CAPTURE.
  - CAPTURE: trace_valid_o = 1 and trace_data_o = next_i. On trace_valid_o & trace_ready_i:
    - state reg <= next_i
    - step_cnt += 1
    - toggle_acc += popcount(state reg ^ next_i), saturating at 2^TOG_W-1
    - next state is DONE if the new step_cnt == num_steps, else SETTLE
  - CAPTURE with trace_ready_i low: hold with trace_valid_o high. next_i must be stable while stalled, because state_o does not change.
  - DONE (1 cycle): done_o = 1, then go to IDLE.
- trace_valid_o is high only in CAPTURE.
- Timing with SETTLE=1 and ready held high: start_i sampled in cycle 0; LOAD in c1; SETTLE/CAPTURE alternate from c2; done_o in cycle 2 + 2*num_steps.
- start_i while busy is ignored.
- abort_i in any non-IDLE state (priority over all other events):
  - next cycle the FSM is in IDLE, trace_valid_o = 0, no done_o.
  - step_cnt, toggle_acc and the state register keep their current values.
- abort_i in IDLE is ignored.
- rst mid-run gives the full reset values on the next cycle.
- step_cnt wraps only if num_steps = 2^CNT_W-1 is reached; it never exceeds num_steps.
- Step accept and abort in the same cycle: abort wins; the step is not counted.

Optional Feature:
- Macro NSL_FIXPOINT_STOP_EN.
- Defined: on an accepted step where next_i == state reg, the step is counted (toggle contribution 0), fixpoint_o is set, and the FSM goes to DONE regardless of the remaining count. fixpoint_o holds until the next LOAD or rst.
- Undefined: the run always executes num_steps steps and fixpoint_o is tied 0.

Test Plan:
- rst high for 2 cycles mid-CAPTURE -> all outputs 0, FSM IDLE, busy_o=0.
- seed=9'h014, num_steps=3, next_i = state rotated left 1, ready=1, SETTLE=1 -> trace_data 9'h028, 9'h050, 9'h0A0; done_o in cycle 8; step_cnt=3; toggle_acc=12.
- Same run with trace_ready_i low for 4 cycles at the first capture -> trace_valid_o held, data 9'h028 stable, done_o delayed to cycle 12, toggle_acc=12.
- num_steps=0, seed=9'h1FF -> LOAD then DONE; done_o in cycle 2; state_o=9'h1FF; no trace_valid_o.
- abort_i asserted in the second SETTLE of a 5-step run -> IDLE next cycle, step_cnt=1, no done_o; a subsequent start_i runs a fresh run normally.
- NSL_FIXPOINT_STOP_EN defined, seed=9'h000, next_i=9'h000, num_steps=10 -> one step, fixpoint_o=1, step_cnt=1, toggle_acc=0. Macro undefined -> 10 steps, fixpoint_o=0.
